// File: rtl/mem_access_unit_if.sv
// Request/response and data-memory bus bundle for mem_access_unit.
// The slave modport is the unit's view; the master modport is the
// environment's view (MEM stage plus data memory).
interface mem_access_unit_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16
);
    // request side
    logic                    req_valid;
    logic                    req_ready;
    logic [1:0]              req_op;
    logic                    req_indirect;
    logic [ADDR_WIDTH-1:0]   req_addr;
    logic [DATA_WIDTH-1:0]   req_wdata;

    // response side
    logic                    resp_valid;
    logic [DATA_WIDTH-1:0]   resp_rdata;
    logic [ADDR_WIDTH-1:0]   resp_addr;
    logic                    busy;

    // data-memory port
    logic [ADDR_WIDTH-1:0]   mem_address;
    logic                    mem_read;
    logic                    mem_write;
    logic [DATA_WIDTH-1:0]   mem_wdata;
    logic [DATA_WIDTH/8-1:0] mem_byte_enable;
    logic                    mem_resp;
    logic [DATA_WIDTH-1:0]   mem_rdata;

    modport slave (
        input  req_valid, req_op, req_indirect, req_addr, req_wdata,
        input  mem_resp, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_addr, busy,
        output mem_address, mem_read, mem_write, mem_wdata, mem_byte_enable
    );

    modport master (
        output req_valid, req_op, req_indirect, req_addr, req_wdata,
        output mem_resp, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_addr, busy,
        input  mem_address, mem_read, mem_write, mem_wdata, mem_byte_enable
    );
endinterface

// File: rtl/mem_access_unit.sv
// Data-memory access sequencer: one load/store at a time, optional
// hardware pointer chasing (IND_LEVELS pointer reads) before the final
// access, and byte-lane steering for any power-of-two data width.
module mem_access_unit #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16,
    parameter int IND_LEVELS = 1
) (
    input  logic            clk,
    input  logic            reset_n,
    mem_access_unit_if.slave bus
);
    localparam int B  = DATA_WIDTH / 8;
    localparam int LB = $clog2(B);
    localparam logic [ADDR_WIDTH-1:0] LANE_MASK  = ADDR_WIDTH'(B - 1);
    localparam logic [1:0]            LAST_LEVEL = 2'(IND_LEVELS - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_PTR    = 2'd1,
        S_ACCESS = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [1:0]              level_q, level_d;
    logic [1:0]              op_q, op_d;          // [0]=write, [1]=byte
    logic                    ind_q, ind_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;      // current pointer / final address
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;

    logic [ADDR_WIDTH-1:0]   mem_address_q, mem_address_d;
    logic                    mem_read_q, mem_read_d;
    logic                    mem_write_q, mem_write_d;
    logic [DATA_WIDTH-1:0]   mem_wdata_q, mem_wdata_d;
    logic [B-1:0]            mem_be_q, mem_be_d;
    logic                    resp_valid_q, resp_valid_d;
    logic [DATA_WIDTH-1:0]   resp_rdata_q, resp_rdata_d;
    logic [ADDR_WIDTH-1:0]   resp_addr_q, resp_addr_d;

    logic                    req_ready;
    logic                    accept;
    logic                    mem_done;
    logic [LB-1:0]           lane;
    logic [ADDR_WIDTH-1:0]   aligned_addr;
    logic [7:0]              rd_byte;

    assign req_ready    = (state_q == S_IDLE) || (state_q == S_RESP);
    assign accept       = bus.req_valid && req_ready;
    // a memory handshake only counts while a strobe is actually out
    assign mem_done     = (mem_read_q || mem_write_q) && bus.mem_resp;
    assign lane         = addr_q[LB-1:0];
    assign aligned_addr = addr_q & ~LANE_MASK;
    assign rd_byte      = 8'(bus.mem_rdata >> {lane, 3'b000});

    // next-state, request latching and registered memory-port values
    always_comb begin
        state_d       = state_q;
        level_d       = level_q;
        op_d          = op_q;
        ind_d         = ind_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        mem_address_d = '0;
        mem_read_d    = 1'b0;
        mem_write_d   = 1'b0;
        mem_wdata_d   = '0;
        mem_be_d      = '0;
        resp_valid_d  = 1'b0;
        resp_rdata_d  = resp_rdata_q;
        resp_addr_d   = resp_addr_q;

        case (state_q)
            S_IDLE, S_RESP: begin
                if (accept) begin
                    op_d    = bus.req_op;
                    ind_d   = bus.req_indirect;
                    addr_d  = bus.req_addr;
                    wdata_d = bus.req_wdata;
                    level_d = 2'd0;
                    state_d = bus.req_indirect ? S_PTR : S_ACCESS;
                end else if (state_q == S_RESP) begin
                    state_d = S_IDLE;
                end
            end

            S_PTR: begin
                if (mem_done) begin
                    // strobe drops on this edge; a further level re-strobes next cycle
                    addr_d = ADDR_WIDTH'(bus.mem_rdata);
                    if (level_q == LAST_LEVEL) begin
                        state_d = S_ACCESS;
                    end else begin
                        level_d = level_q + 2'd1;
                    end
                end else begin
                    mem_read_d    = 1'b1;
                    mem_address_d = aligned_addr;
                    mem_be_d      = {B{1'b1}};
                end
            end

            S_ACCESS: begin
                if (mem_done) begin
                    state_d      = S_RESP;
                    resp_valid_d = 1'b1;
                    if (op_q[0]) begin
                        resp_rdata_d = '0;
                    end else if (op_q[1]) begin
                        resp_rdata_d = DATA_WIDTH'(rd_byte);
                    end else begin
                        resp_rdata_d = bus.mem_rdata;
                    end
                    resp_addr_d = op_q[1] ? addr_q : aligned_addr;
                end else begin
                    mem_read_d    = ~op_q[0];
                    mem_write_d   = op_q[0];
                    mem_address_d = aligned_addr;
                    if (op_q[1]) begin
                        mem_be_d    = B'(1) << lane;
                        mem_wdata_d = {B{wdata_q[7:0]}};
                    end else begin
                        mem_be_d    = {B{1'b1}};
                        mem_wdata_d = wdata_q;
                    end
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // state and output registers; reset kills any strobe immediately
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            level_q       <= 2'd0;
            op_q          <= 2'd0;
            ind_q         <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            mem_address_q <= '0;
            mem_read_q    <= 1'b0;
            mem_write_q   <= 1'b0;
            mem_wdata_q   <= '0;
            mem_be_q      <= '0;
            resp_valid_q  <= 1'b0;
            resp_rdata_q  <= '0;
            resp_addr_q   <= '0;
        end else begin
            state_q       <= state_d;
            level_q       <= level_d;
            op_q          <= op_d;
            ind_q         <= ind_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            mem_address_q <= mem_address_d;
            mem_read_q    <= mem_read_d;
            mem_write_q   <= mem_write_d;
            mem_wdata_q   <= mem_wdata_d;
            mem_be_q      <= mem_be_d;
            resp_valid_q  <= resp_valid_d;
            resp_rdata_q  <= resp_rdata_d;
            resp_addr_q   <= resp_addr_d;
        end
    end

    assign bus.req_ready       = req_ready;
    assign bus.busy            = (state_q != S_IDLE);
    assign bus.resp_valid      = resp_valid_q;
    assign bus.resp_rdata      = resp_rdata_q;
    assign bus.resp_addr       = resp_addr_q;
    assign bus.mem_address     = mem_address_q;
    assign bus.mem_read        = mem_read_q;
    assign bus.mem_write       = mem_write_q;
    assign bus.mem_wdata       = mem_wdata_q;
    assign bus.mem_byte_enable = mem_be_q;

endmodule
